fft_window_loader: RTL and testbench
====================================

# fft_window_loader

Serial-to-parallel front end for the FFT. The loader accepts audio samples one at a time on a valid/ready stream and assembles them into the flat window bus the FFT consumes. It presents a full window with a valid/ready handshake, and holds the window stable until the consumer takes it. After each window it optionally retains an overlap of the newest samples, so consecutive windows advance by a fixed hop.

## Interface
- window_size, 4096: samples per window. Power of two, ≥ 2.
- value_width, 16: bits per sample, signed two's complement.
- hop, window_size/2: new samples per window after the first. Elaboration error unless 1 ≤ hop ≤ window_size.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sample_in  input  value_width  incoming sample.
- sample_valid  input  1  sample_in is meaningful.
- sample_ready  output  1  loader accepts a sample this cycle.
- window  output  window_size*value_width  sample i at window[i*value_width +: value_width]; index 0 is the oldest sample.
- window_valid  output  1  window holds a complete frame.
- window_ready  input  1  consumer takes the frame.
- fill_count  output  $clog2(window_size+1)  samples currently held.
- frame_count  output  16  windows handed off since reset; wraps from 0xFFFF to 0.

## Operation
- **States.**
  - FILL: sample_ready=1, window_valid=0.
  - HOLD: sample_ready=0, window_valid=1.
- **Accept.** A sample is accepted when sample_valid && sample_ready.
  - On accept, window shifts down one slot: slot i ← slot i+1, and slot window_size-1 ← sample_in. The old slot 0 is discarded.
  - fill_count increments by 1.
- **FILL → HOLD.** Occurs on the accept that brings fill_count to window_size.
- **HOLD.**
  - No shifting; window is bit-stable.
  - sample_valid is ignored and the sample is not consumed.
- **HOLD → FILL.** Occurs on window_valid && window_ready.
  - frame_count increments.
  - fill_count ← window_size − hop (overlap build) or 0 (see Configuration).
  - window contents are untouched. The retained newest samples already occupy slots hop..window_size-1 and slide down as new samples arrive.
- **Simultaneous events.** sample_valid in the same cycle as the HOLD handshake is not accepted, because sample_ready is 0 in HOLD. The first accept can occur on the next cycle.
- **Reset.** Reset at any point, including mid-fill or mid-hold:
  - state ← FILL; window, fill_count and frame_count ← 0.
  - The partial frame is discarded.
- **Reset output values.** sample_ready=1, window_valid=0, window=0, fill_count=0, frame_count=0.
- **Arithmetic.** Samples pass through bit-exact. No scaling, sign handling or saturation.

## Timing
- sample_ready and window_valid decode directly from the registered state. There is no combinational path from any input to either output.
- Latency: window_valid rises on the clock edge that accepts the window_size-th sample of a frame.
- Throughput: one sample per cycle in FILL.
- Per-frame dead time: at least one cycle in HOLD. Steady state is hop+1 cycles per frame with the consumer always ready.
- window, window_valid, fill_count and frame_count are all registered outputs.
- Consumer contract: may hold window_ready low indefinitely. The loader never drops a valid bit or alters window while window_valid=1.

## Configuration
- Macro: FFT_WIN_OVERLAP_EN.
- **Defined:** after handoff, fill_count ← window_size − hop. The next window arrives after hop new samples.
- **Undefined:**
  - The hop parameter is ignored and behaviour is as if hop = window_size.
  - fill_count ← 0, and every window consists of window_size fresh samples.
  - The overlap subtraction logic is not compiled.

## Structure
- Shared package/include fft_defs:
  - WINDOW_SIZE and VALUE_WIDTH default constants, shared with the FFT block.
  - HOP_DEFAULT.
  - Loader state encoding (FILL=0, HOLD=1).
- One sub-module, window_shift_reg: parameterised window_size × value_width shift register with a shift enable, an async-reset clear, and the flat window output.
- The FSM and counters live in fft_window_loader.

## Test plan
All scenarios use window_size=8, value_width=16, hop=4 unless noted.
- **Reset:** assert rst mid-run → sample_ready=1, window_valid=0, window=0, fill_count=0, frame_count=0 immediately, without waiting for a clock edge.
- **First fill:** feed samples 1..8 back-to-back with window_ready=0 → window_valid=1 right after the 8th accept. Expect window slots 0..7 = 1..8, fill_count=8, sample_ready=0.
- **Backpressure:** from the previous state, hold sample_valid=1 and window_ready=0 for 5 cycles → window unchanged, no accepts. Then pulse window_ready=1 → FILL next cycle, frame_count=1, fill_count=4.
- **Overlap (macro defined):** feed 9..12 → window = 5..12, window_valid=1 after the 4th accept.
- **Overlap disabled (macro undefined):** after the first handoff expect fill_count=0. Feed 9..16 → window = 9..16.
- **Reset mid-fill:** accept 3 samples, pulse rst, then feed 21..28 → window = 21..28 and frame_count=0 at window_valid.

Source files
------------

// File: rtl/fft_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_defs (package)
// Description : Shared FFT constants (default window geometry and hop) and
//               the window loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_defs;

  // Default window geometry, shared with the FFT core.
  localparam int WINDOW_SIZE_DEFAULT = 4096;
  localparam int VALUE_WIDTH_DEFAULT = 16;
  localparam int HOP_DEFAULT         = WINDOW_SIZE_DEFAULT / 2;

  // Loader FSM encoding.
  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } loader_state_t;

endpackage : fft_defs
`default_nettype wire

// File: rtl/window_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : window_shift_reg
// Description : WINDOW_SIZE x VALUE_WIDTH shift register. On shift_en every
//               slot moves down one position (slot 0 is the oldest sample) and
//               the new sample enters the top slot. Async reset clears all.
// Revision    : 1.0 - initial release
// ============================================================================
module window_shift_reg #(
  parameter int WINDOW_SIZE = 8,
  parameter int VALUE_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               shift_en,
  input  logic [VALUE_WIDTH-1:0]             sample_in,
  output logic [WINDOW_SIZE*VALUE_WIDTH-1:0] window
);

  localparam int c_bits = WINDOW_SIZE * VALUE_WIDTH;

  logic [c_bits-1:0] r_window;

  // Shift toward slot 0; the newest sample always lands in the top slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_window <= '0;
    end else if (shift_en) begin
      r_window <= {sample_in, r_window[c_bits-1:VALUE_WIDTH]};
    end
  end

  assign window = r_window;

endmodule : window_shift_reg
`default_nettype wire

// File: rtl/fft_window_loader.sv
`default_nettype none
// ============================================================================
// Module      : fft_window_loader
// Description : Serial-to-parallel FFT front end. Collects samples from a
//               valid/ready stream into a flat window bus, hands the full
//               window off with a valid/ready handshake and holds it stable
//               until taken.
//               Macro FFT_WIN_OVERLAP_EN: when defined, the newest
//               WINDOW_SIZE-HOP samples are retained after each handoff so
//               consecutive windows advance by HOP; when undefined, every
//               window is built from WINDOW_SIZE fresh samples.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_window_loader
  import fft_defs::*;
#(
  parameter int WINDOW_SIZE = WINDOW_SIZE_DEFAULT,
  parameter int VALUE_WIDTH = VALUE_WIDTH_DEFAULT,
  parameter int HOP         = WINDOW_SIZE / 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [VALUE_WIDTH-1:0]             sample_in,
  input  logic                               sample_valid,
  output logic                               sample_ready,
  output logic [WINDOW_SIZE*VALUE_WIDTH-1:0] window,
  output logic                               window_valid,
  input  logic                               window_ready,
  output logic [$clog2(WINDOW_SIZE+1)-1:0]   fill_count,
  output logic [15:0]                        frame_count
);

  localparam int c_cnt_w = $clog2(WINDOW_SIZE + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WINDOW_SIZE - 1);

`ifdef FFT_WIN_OVERLAP_EN
  // Overlapped samples already sit in the top slots, so the count restarts there.
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(WINDOW_SIZE - HOP);
`else
  localparam logic [c_cnt_w-1:0] c_reload = '0;
`endif

  // Reject illegal geometry at elaboration time.
  generate
    if ((WINDOW_SIZE < 2) || ((WINDOW_SIZE & (WINDOW_SIZE - 1)) != 0)) begin : g_size_check
      $error("fft_window_loader: WINDOW_SIZE must be a power of two >= 2");
    end
    if ((HOP < 1) || (HOP > WINDOW_SIZE)) begin : g_hop_check
      $error("fft_window_loader: HOP must satisfy 1 <= HOP <= WINDOW_SIZE");
    end
  endgenerate

  loader_state_t      r_state;
  logic [c_cnt_w-1:0] r_fill;
  logic [15:0]        r_frames;
  logic               w_accept;

  // Handshake outputs decode straight from the state register.
  assign sample_ready = (r_state == ST_FILL);
  assign window_valid = (r_state == ST_HOLD);
  assign w_accept     = sample_valid && (r_state == ST_FILL);

  assign fill_count  = r_fill;
  assign frame_count = r_frames;

  // Loader FSM: fill until the window is complete, then hold for the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_FILL;
      r_fill   <= '0;
      r_frames <= '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (sample_valid) begin
            r_fill <= r_fill + c_cnt_w'(1);
            if (r_fill == c_last) begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (window_ready) begin
            r_state  <= ST_FILL;
            r_fill   <= c_reload;
            r_frames <= r_frames + 16'd1;
          end
        end
        default: begin
          r_state <= ST_FILL;
        end
      endcase
    end
  end

  window_shift_reg #(
    .WINDOW_SIZE (WINDOW_SIZE),
    .VALUE_WIDTH (VALUE_WIDTH)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (w_accept),
    .sample_in (sample_in),
    .window    (window)
  );

endmodule : fft_window_loader
`default_nettype wire

// File: tb/tb_fft_window_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_window_loader
// Description : Self-checking bench for fft_window_loader (8 x 16, hop 4).
//               Directed table, hand-written corner sequences and a random
//               phase, all checked against a history-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_window_loader;

  localparam int WS = 8;
  localparam int VW = 16;
  localparam int HP = 4;
  localparam int CW = $clog2(WS + 1);
`ifdef FFT_WIN_OVERLAP_EN
  localparam int RELOAD = WS - HP;
`else
  localparam int RELOAD = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [VW-1:0]    sample_in;
  logic             sample_valid;
  logic             sample_ready;
  logic [WS*VW-1:0] window;
  logic             window_valid;
  logic             window_ready;
  logic [CW-1:0]    fill_count;
  logic [15:0]      frame_count;

  always #5 clk = ~clk;

  fft_window_loader #(
    .WINDOW_SIZE (WS),
    .VALUE_WIDTH (VW),
    .HOP         (HP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .window       (window),
    .window_valid (window_valid),
    .window_ready (window_ready),
    .fill_count   (fill_count),
    .frame_count  (frame_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: history of accepted samples, the fill level, frame count
  // and whether a complete window is waiting for the consumer.
  int          acc[$];
  int          m_fill;
  logic [15:0] m_frames;
  bit          m_hold;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The window is simply the newest WS accepted samples, oldest in slot 0.
  function automatic logic [WS*VW-1:0] model_window();
    logic [WS*VW-1:0] w;
    w = '0;
    for (int i = 0; i < WS; i++) begin
      int idx;
      int v;
      idx = acc.size() - WS + i;
      if (idx >= 0) begin
        v = acc[idx];
        w[i*VW +: VW] = VW'(v);
      end
    end
    return w;
  endfunction

  function automatic logic [WS*VW-1:0] mk_win(input int base);
    logic [WS*VW-1:0] w;
    for (int i = 0; i < WS; i++) w[i*VW +: VW] = VW'(base + i);
    return w;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_ready"},  {127'd0, sample_ready}, {127'd0, !m_hold});
    chk({tag, "_valid"},  {127'd0, window_valid}, {127'd0, m_hold});
    chk({tag, "_window"}, window, model_window());
    chk({tag, "_fill"},   fill_count, m_fill);
    chk({tag, "_frames"}, frame_count, m_frames);
  endtask

  task automatic model_clear();
    acc.delete();
    m_fill   = 0;
    m_frames = '0;
    m_hold   = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, sample after the edge.
  task automatic cycle(input bit sv, input logic [VW-1:0] d, input bit wr, input string tag);
    sample_valid = sv;
    sample_in    = d;
    window_ready = wr;
    if (!m_hold) begin
      if (sv) begin
        acc.push_back(int'(d));
        while (acc.size() > WS) void'(acc.pop_front());
        m_fill++;
        if (m_fill == WS) m_hold = 1'b1;
      end
    end else if (wr) begin
      m_hold   = 1'b0;
      m_frames = m_frames + 16'd1;
      m_fill   = RELOAD;
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    #1;
    rst = 1'b1;
    #1;
    chk({tag, "_rst_ready"},  {127'd0, sample_ready}, 128'd1);
    chk({tag, "_rst_valid"},  {127'd0, window_valid}, 128'd0);
    chk({tag, "_rst_window"}, window, 128'd0);
    chk({tag, "_rst_fill"},   fill_count, 128'd0);
    chk({tag, "_rst_frames"}, frame_count, 128'd0);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  typedef struct {
    bit          sv;
    logic [15:0] d;
    bit          wr;
    bit          e_valid;
    int          e_fill;
    int          e_frame;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // First fill 1..8 with the consumer stalled.
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 16'(i + 1), 1'b0, (i == 7), i + 1, 0};
    // Backpressure: valid samples offered while holding are not taken.
    for (int i = 8; i < 13; i++) tbl[i] = '{1'b1, 16'hBEEF, 1'b0, 1'b1, 8, 0};
    // Handoff with a sample also offered: sample is not accepted.
    tbl[13] = '{1'b1, 16'h7777, 1'b1, 1'b0, RELOAD, 1};

    rst          = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    window_ready = 1'b0;
    model_clear();
    #2;
    chk("por_ready",  {127'd0, sample_ready}, 128'd1);
    chk("por_valid",  {127'd0, window_valid}, 128'd0);
    chk("por_window", window, 128'd0);
    chk("por_fill",   fill_count, 128'd0);
    chk("por_frames", frame_count, 128'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].sv, tbl[i].d, tbl[i].wr, "tbl");
      chk("tbl_valid_exp", {127'd0, window_valid}, {127'd0, tbl[i].e_valid});
      chk("tbl_fill_exp",  fill_count, tbl[i].e_fill);
      chk("tbl_frame_exp", frame_count, tbl[i].e_frame);
      if (i >= 7) chk("tbl_window_exp", window, mk_win(1));
    end

`ifdef FFT_WIN_OVERLAP_EN
    for (int i = 9; i <= 12; i++) begin
      cycle(1'b1, 16'(i), 1'b0, "ovl");
      chk("ovl_valid_exp", {127'd0, window_valid}, {127'd0, (i == 12)});
    end
    chk("ovl_window_exp", window, mk_win(5));
`else
    for (int i = 9; i <= 16; i++) begin
      cycle(1'b1, 16'(i), 1'b0, "fresh");
      chk("fresh_valid_exp", {127'd0, window_valid}, {127'd0, (i == 16)});
    end
    chk("fresh_window_exp", window, mk_win(9));
`endif
    cycle(1'b0, 16'h0, 1'b1, "handoff2");
    chk("handoff2_frames_exp", frame_count, 128'd2);

    // Reset mid-fill discards the partial frame.
    cycle(1'b1, 16'd31, 1'b0, "midfill");
    cycle(1'b1, 16'd32, 1'b0, "midfill");
    cycle(1'b1, 16'd33, 1'b0, "midfill");
    async_reset("midfill");
    for (int i = 21; i <= 28; i++) cycle(1'b1, 16'(i), 1'b0, "refill");
    chk("refill_window_exp", window, mk_win(21));
    chk("refill_frames_exp", frame_count, 128'd0);
    chk("refill_valid_exp",  {127'd0, window_valid}, 128'd1);

    // Reset while holding a complete window.
    async_reset("midhold");

    // Randomised traffic with occasional asynchronous resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) async_reset("rnd");
      cycle(($urandom_range(0, 3) != 0), VW'($urandom), ($urandom_range(0, 2) == 0), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fft_window_loader
`default_nettype wire
